// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage of a pipelined MIPS CPU. Owns the PC, drives the
// word address to instruction memory (which answers combinationally) and
// captures the returned word into the IF/ID pipeline register.
//
// Handles hazard stalls, branch/jump redirects with delay-slot semantics,
// IF/ID flushes, and redirects that arrive while the stage is stalled. A
// redirect seen during a stall is remembered and applied when the stall drops.
//
// Ports:
//   clk             pipeline clock, all state updates on posedge
//   rst             synchronous active-high reset
//   stall           hold PC and IF/ID
//   flush           replace IF/ID contents with a bubble
//   redirect_valid  branch taken / jump resolved in ID
//   redirect_target new fetch address
//   iaddr           fetch address to instruction memory (= PC register)
//   idata           instruction word from instruction memory, same cycle
//   id_instr        IF/ID instruction
//   id_pc           IF/ID PC of that instruction
//   id_pc4          IF/ID PC+4
//   id_valid        IF/ID holds a real instruction
//   misalign_err    one-cycle pulse: a non-word-aligned target was taken
//   fetch_count     number of instructions delivered to ID
// ----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q,          pc_d;
    logic        redir_pend_q,  redir_pend_d;
    logic [31:0] redir_tgt_q,   redir_tgt_d;
    logic [31:0] id_instr_q,    id_instr_d;
    logic [31:0] id_pc_q,       id_pc_d;
    logic [31:0] id_pc4_q,      id_pc4_d;
    logic        id_valid_q,    id_valid_d;
    logic        misalign_q,    misalign_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        eff_v_s;
    logic [31:0] eff_t_s;
    logic [31:0] pc_plus4_s;

    // Fetch address comes straight from the PC register; no input reaches it.
    assign iaddr        = pc_q;
    assign id_instr     = id_instr_q;
    assign id_pc        = id_pc_q;
    assign id_pc4       = id_pc4_q;
    assign id_valid     = id_valid_q;
    assign misalign_err = misalign_q;
    assign fetch_count  = fetch_count_q;

    // Effective redirect: a live request wins over a remembered one.
    always_comb begin
        eff_v_s    = redirect_valid | redir_pend_q;
        eff_t_s    = redirect_valid ? redirect_target : redir_tgt_q;
        pc_plus4_s = pc_q + 32'd4;
    end

    // PC and pending-redirect next state.
    always_comb begin
        pc_d         = pc_q;
        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;
        misalign_d   = 1'b0;
        if (stall) begin
            // PC frozen; remember the newest redirect for when the stall drops.
            if (redirect_valid) begin
                redir_pend_d = 1'b1;
                redir_tgt_d  = redirect_target;
            end else begin
                redir_pend_d = redir_pend_q;
            end
        end else if (eff_v_s) begin
            // Low bits are forced to zero; a non-zero pair is reported.
            pc_d         = {eff_t_s[31:2], 2'b00};
            redir_pend_d = 1'b0;
            misalign_d   = (eff_t_s[1:0] != 2'b00);
        end else begin
            pc_d = pc_plus4_s;
        end
    end

    // IF/ID next state. The word at iaddr is the delay slot and is kept even
    // when a redirect is taken; only flush turns it into a bubble.
    always_comb begin
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc4_d      = id_pc4_q;
        id_valid_d    = id_valid_q;
        fetch_count_d = fetch_count_q;
        if (flush) begin
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
        end else if (stall) begin
            id_valid_d = id_valid_q;
        end else begin
            id_instr_d    = idata;
            id_pc_d       = pc_q;
            id_pc4_d      = pc_plus4_s;
            id_valid_d    = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // State registers with synchronous reset that overrides all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            redir_pend_q  <= 1'b0;
            redir_tgt_q   <= 32'h0000_0000;
            id_instr_q    <= NOP_INSTR;
            id_pc_q       <= 32'h0000_0000;
            id_pc4_q      <= 32'h0000_0000;
            id_valid_q    <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_count_q <= 32'h0000_0000;
        end else begin
            pc_q          <= pc_d;
            redir_pend_q  <= redir_pend_d;
            redir_tgt_q   <= redir_tgt_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc4_q      <= id_pc4_d;
            id_valid_q    <= id_valid_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

endmodule
